// File: rtl/if_id_fifo.sv
// Fetch-to-decode instruction buffer: circular queue of {PC, instruction} pairs
// with valid/ready handshakes on both sides and a single-cycle wrong-path flush.
module if_id_fifo #(
  parameter int              DEPTH = 4,
  parameter int              XLEN  = 32,
  parameter logic [XLEN-1:0] NOP   = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     f_valid,
  input  logic [XLEN-1:0]          f_pc,
  input  logic [XLEN-1:0]          f_inst,
  output logic                     f_ready,
  output logic                     d_valid,
  output logic [XLEN-1:0]          d_pc,
  output logic [XLEN-1:0]          d_inst,
  input  logic                     d_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_count;
  logic [XLEN-1:0] r_mem_pc   [DEPTH];
  logic [XLEN-1:0] r_mem_inst [DEPTH];

  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [AW-1:0]   w_wr_idx;
  logic [AW-1:0]   w_rd_idx;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);

  // Ready depends only on occupancy, so a full buffer never passes a pop through.
  assign f_ready  = (r_count != FULL_CNT);
  assign d_valid  = ~w_empty & ~flush;
  assign w_push   = f_valid & f_ready & ~flush;
  assign w_pop    = d_valid & d_ready;

  assign d_pc     = w_empty ? '0  : r_mem_pc[w_rd_idx];
  assign d_inst   = w_empty ? NOP : r_mem_inst[w_rd_idx];
  assign count    = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + PW'(1);
        2'b01:   r_count <= r_count - PW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left unreset; stale contents are hidden by the empty mask above.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[w_wr_idx]   <= f_pc;
      r_mem_inst[w_wr_idx] <= f_inst;
    end
  end

endmodule
